// File: rtl/lock_pkg.sv
// Shared definitions for the keypad-lock controller and the display side.
package lock_pkg;

  localparam logic [1:0] ST_INIT     = 2'b00;
  localparam logic [1:0] ST_UNLOCKED = 2'b01;
  localparam logic [1:0] ST_LOCKED   = 2'b10;

  localparam int unsigned CODE_LEN = 4;

  localparam logic [4:0] BLANK_DIGIT = 5'b10100;

  typedef enum logic [1:0] {
    S_INIT     = ST_INIT,
    S_UNLOCKED = ST_UNLOCKED,
    S_LOCKED   = ST_LOCKED
  } lock_state_e;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'b111) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/lock_controller_if.sv
// Keypad event inputs and display-facing outputs of the lock controller.
interface lock_controller_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       enter;
  logic       lock;
  logic       clear;
  logic [3:0] hex1;
  logic [3:0] hex2;
  logic [3:0] hex3;
  logic [3:0] hex4;
  logic [2:0] counter;
  logic [1:0] state;
  logic       lockout;
  logic       bad_code;

  modport master (
    output digit_valid, digit, enter, lock, clear,
    input  hex1, hex2, hex3, hex4, counter, state, lockout, bad_code
  );

  modport slave (
    input  digit_valid, digit, enter, lock, clear,
    output hex1, hex2, hex3, hex4, counter, state, lockout, bad_code
  );
endinterface

// File: rtl/lockout_timer.sv
// Down-counter that holds `active` high for exactly LOCKOUT_CYCLES cycles after `load`.
module lockout_timer #(
  parameter int LOCKOUT_CYCLES = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done,
  output logic active
);

  localparam int W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(LOCKOUT_CYCLES);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      count  <= LOAD_VAL;
      active <= 1'b1;
    end else if (count != '0) begin
      count <= count - W'(1);
      if (count == W'(1)) active <= 1'b0;
    end
  end

  // Flags the edge on which the count reaches zero so the owner can act on that same edge.
  assign done = active && (count == W'(1));

endmodule

// File: rtl/lock_controller.sv
// Keypad-lock sequencer: entry buffer, stored passcode, lock FSM and failed-attempt lockout.
module lock_controller
  import lock_pkg::*;
#(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 100_000_000
) (
  input logic          clock,
  input logic          reset,
  lock_controller_if.slave bus
);

  lock_state_e state_q;
  logic [3:0]  digits [CODE_LEN];
  logic [2:0]  count_q;
  logic [15:0] code_q;
  logic [2:0]  fails_q;
  logic        bad_q;

  logic        lockout;
  logic        expire;
  logic        lock_req;
  logic        full;
  logic        take_enter;
  logic        mismatch;
  logic        load_timer;
  logic [2:0]  fails_inc;
  logic [15:0] entry;

  always_comb begin
    entry      = {digits[0], digits[1], digits[2], digits[3]};
    lock_req   = bus.lock && (state_q == S_UNLOCKED);
    full       = (count_q == 3'(CODE_LEN));
    take_enter = bus.enter && !lock_req && !bus.clear && !lockout && full;
    mismatch   = (entry != code_q);
    fails_inc  = sat_inc(fails_q);
    load_timer = take_enter && (state_q == S_LOCKED) && mismatch
                 && (fails_inc == 3'(MAX_FAILS));
  end

  lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (load_timer),
    .done   (expire),
    .active (lockout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INIT;
      count_q <= '0;
      code_q  <= '0;
      fails_q <= '0;
      bad_q   <= 1'b0;
      for (int unsigned i = 0; i < CODE_LEN; i++) digits[i] <= '0;
    end else begin
      bad_q <= 1'b0;
      if (expire) fails_q <= '0;

      if (lock_req) begin
        state_q <= S_LOCKED;
        count_q <= '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) digits[i] <= '0;
      end else if (!lockout) begin
        if (bus.clear) begin
          count_q <= '0;
          for (int unsigned i = 0; i < CODE_LEN; i++) digits[i] <= '0;
        end else if (bus.enter) begin
          // A short entry leaves the buffer untouched in every state.
          if (take_enter) begin
            count_q <= '0;
            for (int unsigned i = 0; i < CODE_LEN; i++) digits[i] <= '0;
            unique case (state_q)
              S_INIT, S_UNLOCKED: begin
                code_q  <= entry;
                state_q <= S_UNLOCKED;
              end
              S_LOCKED: begin
                if (mismatch) begin
                  bad_q   <= 1'b1;
                  fails_q <= fails_inc;
                end else begin
                  fails_q <= '0;
                  state_q <= S_UNLOCKED;
                end
              end
              default: state_q <= S_INIT;
            endcase
          end
        end else if (bus.digit_valid && !full) begin
          digits[count_q[1:0]] <= bus.digit;
          count_q              <= count_q + 3'd1;
        end
      end
    end
  end

  assign bus.hex1     = digits[0];
  assign bus.hex2     = digits[1];
  assign bus.hex3     = digits[2];
  assign bus.hex4     = digits[3];
  assign bus.counter  = count_q;
  assign bus.state    = state_q;
  assign bus.lockout  = lockout;
  assign bus.bad_code = bad_q;

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller with a short lockout and three allowed failures.
module tb_lock_controller;

  localparam int MF = 3;
  localparam int LC = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lock_controller_if bus ();

  lock_controller #(.MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  state;
    logic [2:0]  counter;
    logic [15:0] hex;
    logic        lockout;
    logic        bad_code;
  } exp_t;

  exp_t sb[$];

  int n_total = 0;
  int n_bad   = 0;
  int lo_seen = 0;
  int bad_seen = 0;

  // Reference model state
  logic [1:0]  m_state;
  logic [2:0]  m_cnt;
  logic [15:0] m_buf;
  logic [15:0] m_code;
  logic [2:0]  m_fails;
  int          m_timer;
  logic        m_bad;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic dv, input logic [3:0] d, input logic en,
                       input logic lk, input logic cl, input logic rs);
    logic was_lo;
    if (rs) begin
      m_state = 2'b00; m_cnt = 0; m_buf = '0; m_code = '0;
      m_fails = 0; m_timer = 0; m_bad = 0;
    end else begin
      was_lo = (m_timer != 0);
      m_bad  = 0;
      if (m_timer != 0) begin
        m_timer--;
        if (m_timer == 0) m_fails = 0;
      end
      if (lk && m_state == 2'b01) begin
        m_state = 2'b10; m_buf = '0; m_cnt = 0;
      end else if (was_lo) begin
      end else if (cl) begin
        m_buf = '0; m_cnt = 0;
      end else if (en) begin
        if (m_cnt == 4) begin
          if (m_state == 2'b10) begin
            if (m_buf == m_code) begin
              m_state = 2'b01; m_fails = 0;
            end else begin
              m_bad = 1;
              if (m_fails != 7) m_fails++;
              if (m_fails == MF) m_timer = LC;
            end
          end else begin
            m_code = m_buf; m_state = 2'b01;
          end
          m_buf = '0; m_cnt = 0;
        end
      end else if (dv && m_cnt < 4) begin
        m_buf[15 - 4*m_cnt -: 4] = d;
        m_cnt++;
      end
    end
  endtask

  task automatic cyc(input logic dv, input logic [3:0] d, input logic en,
                     input logic lk, input logic cl, input logic rs);
    exp_t e;
    exp_t g;
    bus.digit_valid = dv; bus.digit = d; bus.enter = en;
    bus.lock = lk; bus.clear = cl; reset = rs;
    model(dv, d, en, lk, cl, rs);
    e.state = m_state; e.counter = m_cnt; e.hex = m_buf;
    e.lockout = (m_timer != 0); e.bad_code = m_bad;
    sb.push_back(e);
    @(posedge clock);
    #1;
    bus.digit_valid = 0; bus.enter = 0; bus.lock = 0; bus.clear = 0; reset = 0;
    g.state = bus.state; g.counter = bus.counter;
    g.hex = {bus.hex1, bus.hex2, bus.hex3, bus.hex4};
    g.lockout = bus.lockout; g.bad_code = bus.bad_code;
    if (bus.lockout) lo_seen++;
    if (bus.bad_code) bad_seen++;
    if (sb.size() == 0) begin
      chk("sb_empty", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk("state",    16'(g.state),    16'(e.state));
      chk("counter",  16'(g.counter),  16'(e.counter));
      chk("hex",      g.hex,           e.hex);
      chk("lockout",  16'(g.lockout),  16'(e.lockout));
      chk("bad_code", 16'(g.bad_code), 16'(e.bad_code));
    end
  endtask

  task automatic key(input logic [3:0] d);  cyc(1, d, 0, 0, 0, 0); endtask
  task automatic ent();                     cyc(0, 0, 1, 0, 0, 0); endtask
  task automatic lck();                     cyc(0, 0, 0, 1, 0, 0); endtask
  task automatic clr();                     cyc(0, 0, 0, 0, 1, 0); endtask
  task automatic idle();                    cyc(0, 0, 0, 0, 0, 0); endtask
  task automatic rst();                     cyc(0, 0, 0, 0, 0, 1); endtask

  task automatic code4(input logic [15:0] c);
    key(c[15:12]); key(c[11:8]); key(c[7:4]); key(c[3:0]);
    ent();
  endtask

  initial begin
    bus.digit_valid = 0; bus.digit = 0; bus.enter = 0; bus.lock = 0; bus.clear = 0;
    rst(); rst(); idle();

    // Short entry in INIT is ignored, then a full code is stored
    key(4'h1); key(4'h2); ent();
    chk("short_enter_cnt", 16'(bus.counter), 16'd2);
    key(4'h3); key(4'h4); ent();
    chk("init_store_state", 16'(bus.state), 16'h1);

    // Lock and unlock with the right code
    lck();
    chk("locked", 16'(bus.state), 16'h2);
    code4(16'h1234);
    chk("unlocked", 16'(bus.state), 16'h1);

    // Overflow digit ignored, then clear
    lck();
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h9);
    chk("full_hex4", 16'(bus.hex4), 16'h4);
    clr();

    // Three wrong codes trigger lockout; keypad ignored meanwhile
    bad_seen = 0;
    code4(16'h0000);
    code4(16'h0000);
    lo_seen = 0;
    code4(16'h0000);
    for (int i = 0; i < LC + 2; i++) begin
      if (i < 6) key(4'(i + 5)); else if (i == 6) ent(); else idle();
    end
    chk("bad_pulses", 16'(bad_seen), 16'd3);
    chk("lockout_len", 16'(lo_seen), 16'(LC));
    code4(16'h1234);
    chk("post_lockout_unlock", 16'(bus.state), 16'h1);

    // clear wins over digit_valid
    key(4'h1); key(4'h2);
    cyc(1, 4'h7, 0, 0, 1, 0);
    chk("clear_prio", 16'(bus.counter), 16'd0);

    // lock wins over enter; code not replaced
    key(4'h5); key(4'h6); key(4'h7); key(4'h8);
    cyc(0, 0, 1, 1, 0, 0);
    chk("lock_prio", 16'(bus.state), 16'h2);
    code4(16'h5678);
    chk("code_kept_bad", 16'(bus.state), 16'h2);
    code4(16'h1234);
    chk("code_kept_ok", 16'(bus.state), 16'h1);

    // Reset mid-lockout drops everything
    lck();
    code4(16'h0001); code4(16'h0002); code4(16'h0003);
    idle(); idle();
    rst();
    chk("rst_state", 16'(bus.state), 16'h0);
    chk("rst_lockout", 16'(bus.lockout), 16'h0);
    code4(16'h9876);
    lck();
    code4(16'h1234);
    code4(16'h9876);
    chk("new_code", 16'(bus.state), 16'h1);
    idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
